// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned PC_SEL_W = 2;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_ENTER = 2'd2,
    ST_IN_ISR    = 2'd3
  } hazState_e;

  localparam logic [PC_SEL_W-1:0] PC_SEQ    = 2'b00;
  localparam logic [PC_SEL_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PC_SEL_W-1:0] PC_EXC    = 2'b10;
  localparam logic [PC_SEL_W-1:0] PC_EPC    = 2'b11;

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use detector: ID consumer depends on the load currently in EX.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_rs_read,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_read,
  input  logic [REG_W-1:0] id_rt,
  output logic             loadUse
);

  logic rsHit;
  logic rtHit;

  assign rsHit   = id_rs_read && (id_rs == ex_rd);
  assign rtHit   = id_rt_read && (id_rt == ex_rd);
  assign loadUse = ex_mem_read && (ex_rd != REG_W'(0)) && (rsHit || rtHit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/interrupt controller: stalls, flushes and PC source selection.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_rs_read,
  input  logic                id_rt_read,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                ex_mem_read,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic                branch_taken_ex,
  input  logic                eret_id,
  input  logic                mem_req,
  input  logic                mem_ready,
  input  logic                irq_req,
  output logic                irq_ack,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                stall_me,
  output logic                flush_id,
  output logic                flush_ex,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                epc_write,
  output logic                in_isr
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]    stall_cycles
`endif
);

  hazState_e state;
  hazState_e nextState;
  hazState_e origin;
  hazState_e ctxState;
  logic      loadUse;
  logic      memWait;

  load_use_detect u_load_use (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs_read  (id_rs_read),
    .id_rs       (id_rs),
    .id_rt_read  (id_rt_read),
    .id_rt       (id_rt),
    .loadUse     (loadUse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      origin  <= ST_RUN;
      irq_ack <= 1'b0;
    end else begin
      state   <= nextState;
      irq_ack <= (state == ST_IRQ_ENTER);
      if (state != ST_MEM_WAIT && nextState == ST_MEM_WAIT) begin
        origin <= state;
      end
    end
  end

  // MEM_WAIT behaves as its origin state once memory is ready, so the
  // cycle in which the pipeline advances still sees branches and hazards.
  always_comb begin
    nextState = state;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_me  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    pc_sel    = PC_SEQ;
    epc_write = 1'b0;
    in_isr    = 1'b0;
    ctxState  = (state == ST_MEM_WAIT) ? origin : state;
    memWait   = (state == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    if (rst_n) begin
      case (state)
        ST_IRQ_ENTER: begin
          pc_sel    = PC_EXC;
          epc_write = 1'b1;
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          nextState = ST_IN_ISR;
        end
        default: begin
          in_isr    = (ctxState == ST_IN_ISR);
          nextState = ctxState;
          if (memWait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_me  = 1'b1;
            nextState = ST_MEM_WAIT;
          end else if (branch_taken_ex) begin
            pc_sel   = PC_BRANCH;
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (ctxState == ST_RUN && irq_req) begin
            nextState = ST_IRQ_ENTER;
          end else if (loadUse) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end else if (ctxState == ST_IN_ISR && eret_id) begin
            pc_sel    = PC_EPC;
            flush_id  = 1'b1;
            nextState = ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_if && stall_cycles != {CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Output vector order: stall_if,stall_id,stall_ex,stall_me,flush_id,flush_ex,pc_sel[1:0],epc_write,in_isr,irq_ack
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       id_rs_read, id_rt_read;
  logic [4:0] id_rs, id_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       branch_taken_ex, eret_id, mem_req, mem_ready, irq_req;
  logic       irq_ack, stall_if, stall_id, stall_ex, stall_me, flush_id, flush_ex;
  logic [1:0] pc_sel;
  logic       epc_write, in_isr;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs_read      (id_rs_read),
    .id_rt_read      (id_rt_read),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .branch_taken_ex (branch_taken_ex),
    .eret_id         (eret_id),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .irq_req         (irq_req),
    .irq_ack         (irq_ack),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_me        (stall_me),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .pc_sel          (pc_sel),
    .epc_write       (epc_write),
    .in_isr          (in_isr)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic [10:0] exp);
    chk(tag, 32'({stall_if, stall_id, stall_ex, stall_me, flush_id, flush_ex,
                  pc_sel, epc_write, in_isr, irq_ack}), 32'(exp));
  endtask

  task automatic clearIn();
    id_rs_read = 0; id_rt_read = 0; id_rs = 0; id_rt = 0;
    ex_mem_read = 0; ex_rd = 0; branch_taken_ex = 0; eret_id = 0;
    mem_req = 0; mem_ready = 0; irq_req = 0;
  endtask

  // advance one clock, leave time just after the edge for driving inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clearIn();
    #2;
    chkOut("reset_outputs", 11'b00000000000);
    chk("reset_state", 32'(dut.state), 32'(ST_RUN));
`ifdef HAZARD_STATS_EN
    chk("reset_count", stall_cycles, 32'd0);
`endif
    #10 rst_n = 1'b1;

    // load-use on rs
    tick(); ex_mem_read = 1; ex_rd = 5'd8; id_rs_read = 1; id_rs = 5'd8; #1;
    chkOut("loaduse_rs", 11'b11000100000);
    tick(); clearIn(); #1;
    chkOut("loaduse_clears", 11'b00000000000);
    tick(); ex_mem_read = 1; ex_rd = 5'd5; id_rt_read = 1; id_rt = 5'd5; #1;
    chkOut("loaduse_rt", 11'b11000100000);
    tick(); id_rt_read = 0; #1;
    chkOut("loaduse_rt_not_read", 11'b00000000000);
    tick(); ex_rd = 5'd0; id_rs_read = 1; id_rs = 5'd0; #1;
    chkOut("loaduse_r0", 11'b00000000000);

    // memory wait: three stalled cycles, then ready
    tick(); clearIn(); mem_req = 1; #1;
    chkOut("memwait_c1", 11'b11110000000);
    tick(); branch_taken_ex = 1; #1;
    chkOut("memwait_c2_branch_masked", 11'b11110000000);
    tick(); branch_taken_ex = 0; #1;
    chkOut("memwait_c3", 11'b11110000000);
    tick(); mem_ready = 1; #1;
    chkOut("memwait_ready", 11'b00000000000);
    tick(); clearIn(); #1;
    chk("memwait_back_run", 32'(dut.state), 32'(ST_RUN));
    chkOut("memwait_after", 11'b00000000000);

    // branch overrides load-use; eret ignored in RUN
    tick(); branch_taken_ex = 1; ex_mem_read = 1; ex_rd = 5'd3; id_rs_read = 1; id_rs = 5'd3; #1;
    chkOut("branch_over_loaduse", 11'b00001101000);
    tick(); clearIn(); eret_id = 1; #1;
    chkOut("eret_in_run", 11'b00000000000);

    // irq coincident with branch: branch first, irq taken the cycle after
    tick(); clearIn(); irq_req = 1; branch_taken_ex = 1; #1;
    chkOut("irq_branch_c1", 11'b00001101000);
    tick(); branch_taken_ex = 0; #1;
    chkOut("irq_deferred_c2", 11'b00000000000);
    tick(); #1;
    chkOut("irq_enter", 11'b00001110100);
    tick(); #1;
    chkOut("irq_ack_pulse", 11'b00000000011);
    tick(); #1;
    chkOut("in_isr_hold", 11'b00000000010);
    tick(); #1;
    chkOut("second_irq_ignored", 11'b00000000010);

    // hazards inside the ISR
    tick(); irq_req = 0; ex_mem_read = 1; ex_rd = 5'd9; id_rt_read = 1; id_rt = 5'd9; #1;
    chkOut("isr_loaduse", 11'b11000100010);
    tick(); clearIn(); mem_req = 1; #1;
    chkOut("isr_memwait_c1", 11'b11110000010);
    tick(); #1;
    chkOut("isr_memwait_c2", 11'b11110000010);
    tick(); mem_ready = 1; #1;
    chkOut("isr_memwait_ready", 11'b00000000010);
    tick(); clearIn(); #1;
    chk("isr_back_state", 32'(dut.state), 32'(ST_IN_ISR));
    eret_id = 1; #1;
    chkOut("eret", 11'b00001011010);
    tick(); clearIn(); #1;
    chkOut("after_eret", 11'b00000000000);

    // reset in the middle of a memory wait
    tick(); mem_req = 1; #1;
    tick(); #1;
    chkOut("pre_reset_wait", 11'b11110000000);
    rst_n = 0; irq_req = 1; #1;
    chkOut("reset_mid_wait", 11'b00000000000);
    chk("reset_mid_state", 32'(dut.state), 32'(ST_RUN));
`ifdef HAZARD_STATS_EN
    chk("reset_mid_count", stall_cycles, 32'd0);
`endif
    tick(); #1;
    chkOut("irq_held_in_reset", 11'b00000000000);
    chk("no_irq_in_reset", 32'(dut.state), 32'(ST_RUN));
    mem_req = 0; rst_n = 1; #1;
    tick(); #1;
    chkOut("irq_after_reset", 11'b00001110100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
